// File: rtl/mux_n_scan.sv
// rtl/mux_n_scan.sv - registered N-channel W-bit mux with select latch and auto-scan
//
// Purpose: time-multiplexes CHANNELS sources of WIDTH bits onto one registered
// output. The channel comes either from a direct-load select latch or from an
// auto-scan counter that advances on each enable strobe.
//
// Optional feature: define MUXN_SKIP_MASK_EN to add a per-channel skip mask.
//
// Ports:
//   MasterClock - system clock, rising-edge active
//   reset       - synchronous reset, active-high, highest priority
//   enable      - capture strobe; also advances the scan in scan mode
//   scan        - 1 = auto-scan, 0 = direct select
//   sel_load    - direct mode: load sel_in into the select latch
//   sel_in      - requested channel
//   d           - packed channel data, channel k at d[k*WIDTH +: WIDTH]
//   mask        - (MUXN_SKIP_MASK_EN only) 1 = channel skipped
//   q           - registered selected data
//   q_valid     - q holds a captured value
//   cur_sel     - current select latch
//   wrap        - one-cycle pulse after a scan step wraps to a lower index
module mux_n_scan #(
  parameter  int WIDTH    = 1,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      MasterClock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      scan,
  input  logic                      sel_load,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS*WIDTH-1:0] d,
`ifdef MUXN_SKIP_MASK_EN
  input  logic [CHANNELS-1:0]       mask,
`endif
  output logic [WIDTH-1:0]          q,
  output logic                      q_valid,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      wrap
);

  // Select codes can exceed CHANNELS-1 for non-power-of-2 counts; pad the
  // lookup tables to the full code space so every index is in range.
  localparam int SLOTS = 1 << SEL_W;

  logic [WIDTH-1:0] chan [SLOTS];
  logic [WIDTH-1:0] chan_sel;
  logic [SEL_W-1:0] step_sel;
  logic             step_wrap;
  logic             load_ok;
  logic             cap_ok;

  always_comb begin
    for (int k = 0; k < SLOTS; k++) chan[k] = '0;
    for (int k = 0; k < CHANNELS; k++) chan[k] = d[k*WIDTH +: WIDTH];
  end

  assign chan_sel = chan[cur_sel];

`ifdef MUXN_SKIP_MASK_EN
  logic [SLOTS-1:0] mask_ext;
  logic             found;
  int               idx;

  // Unused codes read as masked so an out-of-range load is also rejected.
  always_comb begin
    mask_ext                 = '1;
    mask_ext[CHANNELS-1:0]   = mask;
  end

  // Search forward circularly for the next unmasked channel. Searching a full
  // CHANNELS steps lets a single unmasked channel return to itself.
  always_comb begin
    step_sel  = cur_sel;
    step_wrap = 1'b0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      if (!found) begin
        idx = int'(cur_sel) + i;
        if (idx >= CHANNELS) begin
          idx = idx - CHANNELS;
          if (!mask_ext[idx]) begin
            found     = 1'b1;
            step_sel  = idx[SEL_W-1:0];
            step_wrap = 1'b1;
          end
        end else if (!mask_ext[idx]) begin
          found    = 1'b1;
          step_sel = idx[SEL_W-1:0];
        end
      end
    end
  end

  assign load_ok = (int'(sel_in) < CHANNELS) && !mask_ext[sel_in];
  assign cap_ok  = !mask_ext[cur_sel];
`else
  // Explicit compare so non-power-of-2 counts wrap at CHANNELS-1.
  always_comb begin
    step_wrap = (int'(cur_sel) == CHANNELS - 1);
    step_sel  = step_wrap ? '0 : cur_sel + SEL_W'(1);
  end

  assign load_ok = (int'(sel_in) < CHANNELS);
  assign cap_ok  = 1'b1;
`endif

  always_ff @(posedge MasterClock) begin
    if (reset) begin
      q       <= '0;
      q_valid <= 1'b0;
      cur_sel <= '0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      // Scan mode ignores sel_load entirely, so scan wins when both are active.
      if (scan) begin
        if (enable) begin
          cur_sel <= step_sel;
          wrap    <= step_wrap;
        end
      end else if (sel_load && load_ok) begin
        cur_sel <= sel_in;
      end
      // Capture uses the pre-edge cur_sel.
      if (enable) begin
        if (cap_ok) begin
          q       <= chan_sel;
          q_valid <= 1'b1;
        end else begin
          q_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_n_scan.sv
// tb/tb_mux_n_scan.sv - directed self-checking bench for mux_n_scan
module tb_mux_n_scan;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        scan;
  logic        sel_load;
  logic [1:0]  sel_in4;
  logic [2:0]  sel_in5;
  logic [31:0] d4;
  logic [39:0] d5;
  logic [7:0]  q4;
  logic [7:0]  q5;
  logic        q_valid4;
  logic        q_valid5;
  logic [1:0]  cur_sel4;
  logic [2:0]  cur_sel5;
  logic        wrap4;
  logic        wrap5;
`ifdef MUXN_SKIP_MASK_EN
  logic [3:0]  mask4;
  logic [4:0]  mask5;
`endif

  int errors;
  int checks;

  mux_n_scan #(.WIDTH(8), .CHANNELS(4)) dut4 (
    .MasterClock(clk),
    .reset(reset),
    .enable(enable),
    .scan(scan),
    .sel_load(sel_load),
    .sel_in(sel_in4),
    .d(d4),
`ifdef MUXN_SKIP_MASK_EN
    .mask(mask4),
`endif
    .q(q4),
    .q_valid(q_valid4),
    .cur_sel(cur_sel4),
    .wrap(wrap4)
  );

  mux_n_scan #(.WIDTH(8), .CHANNELS(5)) dut5 (
    .MasterClock(clk),
    .reset(reset),
    .enable(enable),
    .scan(scan),
    .sel_load(sel_load),
    .sel_in(sel_in5),
    .d(d5),
`ifdef MUXN_SKIP_MASK_EN
    .mask(mask5),
`endif
    .q(q5),
    .q_valid(q_valid5),
    .cur_sel(cur_sel5),
    .wrap(wrap5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; scan = 1'b0; sel_load = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; scan = 1'b1; sel_load = 1'b0;
    tick(); tick();
    checks++; if (q4 !== 8'h00) begin errors++; $display("FAIL reset_q got %0h expected 00", q4); end
    checks++; if (q_valid4 !== 1'b0) begin errors++; $display("FAIL reset_q_valid got %0b expected 0", q_valid4); end
    checks++; if (cur_sel4 !== 2'd0) begin errors++; $display("FAIL reset_cur_sel got %0d expected 0", cur_sel4); end
    checks++; if (wrap4 !== 1'b0) begin errors++; $display("FAIL reset_wrap got %0b expected 0", wrap4); end
    reset = 1'b0;
    tick(); tick();
    checks++; if (cur_sel4 !== 2'd2) begin errors++; $display("FAIL midscan_pre_sel got %0d expected 2", cur_sel4); end
    checks++; if (q_valid4 !== 1'b1) begin errors++; $display("FAIL midscan_pre_valid got %0b expected 1", q_valid4); end
    reset = 1'b1;
    tick();
    checks++; if (q4 !== 8'h00) begin errors++; $display("FAIL midscan_reset_q got %0h expected 00", q4); end
    checks++; if (q_valid4 !== 1'b0) begin errors++; $display("FAIL midscan_reset_valid got %0b expected 0", q_valid4); end
    checks++; if (cur_sel4 !== 2'd0) begin errors++; $display("FAIL midscan_reset_sel got %0d expected 0", cur_sel4); end
    checks++; if (wrap4 !== 1'b0) begin errors++; $display("FAIL midscan_reset_wrap got %0b expected 0", wrap4); end
    reset = 1'b0; enable = 1'b0; scan = 1'b0;
  endtask

  task automatic test_direct();
    do_reset();
    sel_in4 = 2'd2; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    checks++; if (cur_sel4 !== 2'd2) begin errors++; $display("FAIL direct_sel got %0d expected 2", cur_sel4); end
    checks++; if (q_valid4 !== 1'b0) begin errors++; $display("FAIL direct_no_capture got %0b expected 0", q_valid4); end
    enable = 1'b1;
    tick();
    enable = 1'b0;
    checks++; if (q4 !== 8'h33) begin errors++; $display("FAIL direct_q got %0h expected 33", q4); end
    checks++; if (q_valid4 !== 1'b1) begin errors++; $display("FAIL direct_valid got %0b expected 1", q_valid4); end
    tick();
    checks++; if (q4 !== 8'h33) begin errors++; $display("FAIL direct_hold_q got %0h expected 33", q4); end
  endtask

  task automatic test_scan();
    logic [7:0] exp_q    [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic [1:0] exp_sel  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       exp_wrap [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    scan = 1'b1; enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (q4 !== exp_q[k]) begin errors++; $display("FAIL scan_q[%0d] got %0h expected %0h", k, q4, exp_q[k]); end
      checks++; if (cur_sel4 !== exp_sel[k]) begin errors++; $display("FAIL scan_sel[%0d] got %0d expected %0d", k, cur_sel4, exp_sel[k]); end
      checks++; if (wrap4 !== exp_wrap[k]) begin errors++; $display("FAIL scan_wrap[%0d] got %0b expected %0b", k, wrap4, exp_wrap[k]); end
    end
    scan = 1'b0; enable = 1'b0;
  endtask

  task automatic test_priority();
    do_reset();
    sel_in5 = 3'd3; sel_load = 1'b1;
    tick();
    checks++; if (cur_sel5 !== 3'd3) begin errors++; $display("FAIL prio_load3 got %0d expected 3", cur_sel5); end
    sel_in5 = 3'd6;
    tick();
    checks++; if (cur_sel5 !== 3'd3) begin errors++; $display("FAIL illegal_sel got %0d expected 3", cur_sel5); end
    sel_in5 = 3'd5;
    tick();
    checks++; if (cur_sel5 !== 3'd3) begin errors++; $display("FAIL illegal_sel5 got %0d expected 3", cur_sel5); end
    scan = 1'b1; enable = 1'b1; sel_in5 = 3'd0;
    tick();
    sel_load = 1'b0;
    checks++; if (cur_sel5 !== 3'd4) begin errors++; $display("FAIL scan_over_load got %0d expected 4", cur_sel5); end
    checks++; if (q5 !== 8'h44) begin errors++; $display("FAIL scan_over_load_q got %0h expected 44", q5); end
    checks++; if (wrap5 !== 1'b0) begin errors++; $display("FAIL prio_nowrap got %0b expected 0", wrap5); end
    tick();
    checks++; if (cur_sel5 !== 3'd0) begin errors++; $display("FAIL wrap5_sel got %0d expected 0", cur_sel5); end
    checks++; if (wrap5 !== 1'b1) begin errors++; $display("FAIL wrap5_pulse got %0b expected 1", wrap5); end
    checks++; if (q5 !== 8'h55) begin errors++; $display("FAIL wrap5_q got %0h expected 55", q5); end
    tick();
    checks++; if (wrap5 !== 1'b0) begin errors++; $display("FAIL wrap5_clear got %0b expected 0", wrap5); end
    scan = 1'b0; enable = 1'b0;
  endtask

  task automatic test_enable_gating();
    logic       pat     [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] exp_sel [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
    logic [7:0] exp_q   [4] = '{8'h11, 8'h11, 8'h11, 8'h22};
    do_reset();
    scan = 1'b1;
    for (int k = 0; k < 4; k++) begin
      enable = pat[k];
      tick();
      checks++; if (cur_sel4 !== exp_sel[k]) begin errors++; $display("FAIL gate_sel[%0d] got %0d expected %0d", k, cur_sel4, exp_sel[k]); end
      checks++; if (q4 !== exp_q[k]) begin errors++; $display("FAIL gate_q[%0d] got %0h expected %0h", k, q4, exp_q[k]); end
    end
    enable = 1'b0;
  endtask

  task automatic test_mode_switch();
    // continues from cur_sel=2 left by test_enable_gating
    scan = 1'b0; enable = 1'b1;
    tick();
    checks++; if (cur_sel4 !== 2'd2) begin errors++; $display("FAIL switch_hold_sel got %0d expected 2", cur_sel4); end
    checks++; if (q4 !== 8'h33) begin errors++; $display("FAIL switch_direct_q got %0h expected 33", q4); end
    checks++; if (wrap4 !== 1'b0) begin errors++; $display("FAIL switch_direct_wrap got %0b expected 0", wrap4); end
    scan = 1'b1;
    tick();
    checks++; if (cur_sel4 !== 2'd3) begin errors++; $display("FAIL switch_resume_sel got %0d expected 3", cur_sel4); end
    checks++; if (q4 !== 8'h33) begin errors++; $display("FAIL switch_resume_q got %0h expected 33", q4); end
    scan = 1'b0; enable = 1'b0;
  endtask

`ifdef MUXN_SKIP_MASK_EN
  task automatic test_mask();
    logic [1:0] exp_sel   [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [7:0] exp_q     [4] = '{8'h00, 8'h22, 8'h44, 8'h22};
    logic       exp_valid [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_wrap  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    mask4 = 4'b0101;
    scan = 1'b1; enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (cur_sel4 !== exp_sel[k]) begin errors++; $display("FAIL mask_sel[%0d] got %0d expected %0d", k, cur_sel4, exp_sel[k]); end
      checks++; if (q4 !== exp_q[k]) begin errors++; $display("FAIL mask_q[%0d] got %0h expected %0h", k, q4, exp_q[k]); end
      checks++; if (q_valid4 !== exp_valid[k]) begin errors++; $display("FAIL mask_valid[%0d] got %0b expected %0b", k, q_valid4, exp_valid[k]); end
      checks++; if (wrap4 !== exp_wrap[k]) begin errors++; $display("FAIL mask_wrap[%0d] got %0b expected %0b", k, wrap4, exp_wrap[k]); end
    end
    mask4 = 4'b1111;
    tick();
    checks++; if (cur_sel4 !== 2'd3) begin errors++; $display("FAIL allmask_sel got %0d expected 3", cur_sel4); end
    checks++; if (q_valid4 !== 1'b0) begin errors++; $display("FAIL allmask_valid got %0b expected 0", q_valid4); end
    checks++; if (q4 !== 8'h22) begin errors++; $display("FAIL allmask_q got %0h expected 22", q4); end
    scan = 1'b0; enable = 1'b0;
    mask4 = 4'b0100; sel_in4 = 2'd2; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    checks++; if (cur_sel4 !== 2'd3) begin errors++; $display("FAIL masked_load got %0d expected 3", cur_sel4); end
    mask4 = 4'b0000;
  endtask
`endif

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    enable   = 1'b0;
    scan     = 1'b0;
    sel_load = 1'b0;
    sel_in4  = '0;
    sel_in5  = '0;
    d4       = {8'h44, 8'h33, 8'h22, 8'h11};
    d5       = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
`ifdef MUXN_SKIP_MASK_EN
    mask4    = '0;
    mask5    = '0;
`endif
    test_reset();
    test_direct();
    test_scan();
    test_priority();
    test_enable_gating();
    test_mode_switch();
`ifdef MUXN_SKIP_MASK_EN
    test_mask();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_n_scan.md
Name: mux_n_scan

Overview:
- Parametrised, registered N-channel, W-bit multiplexer. It generalises the 4:1 single-bit level-function mux in the Slipstream library.
- Adds a registered channel-select latch, an auto-scan mode that steps through channels under an enable strobe, and a registered output with a valid flag.
- Used where Slipstream logic time-multiplexes several sources onto one registered bus, e.g. sequenced status or sample readback.

Parameters:
- WIDTH, 1, data bits per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(CHANNELS), width of the select fields. It is derived and must not be overridden.

Ports:
- MasterClock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous reset, active-high.
- enable  input  1  advance/capture strobe; state holds when low.
- scan  input  1  1 = auto-scan mode, 0 = direct-select mode.
- sel_load  input  1  direct mode: load sel_in into the select latch.
- sel_in  input  SEL_W  requested channel.
- d  input  CHANNELS*WIDTH  packed channel data; channel k is d[k*WIDTH +: WIDTH].
- q  output  WIDTH  registered selected data.
- q_valid  output  1  q holds a captured value.
- cur_sel  output  SEL_W  current select latch.
- wrap  output  1  one-cycle pulse when a scan step wraps from the last channel to channel 0.

Behaviour:
- Clock and reset: one clock, MasterClock. Reset is synchronous and active-high.
  - On reset: q=0, q_valid=0, cur_sel=0, wrap=0.
  - Reset takes priority over every other input in the same cycle.
- Select latch, direct mode (scan=0):
  - sel_load=1 with sel_in < CHANNELS: cur_sel <= sel_in on the next edge.
  - sel_load=1 with sel_in >= CHANNELS: the request is ignored and cur_sel holds.
  - sel_load acts independently of enable.
- Select latch, scan mode (scan=1):
  - enable=1: cur_sel <= cur_sel+1. From CHANNELS-1 it wraps to 0 and wrap=1 for that cycle.
  - sel_load is ignored in scan mode, so scan wins when both are active.
- Output capture:
  - enable=1: q <= channel[cur_sel], using the pre-edge value of cur_sel; q_valid <= 1.
  - enable=0: q and q_valid hold.
- Latency:
  - d to q: 1 cycle after enable.
  - sel_load at edge N: cur_sel is new after edge N. The first q from the new channel appears after edge N+1, with enable high at N+1.
- Scan pairing: in scan mode each captured q corresponds to the channel cur_sel showed before that edge. A bench pairs q with the prior cur_sel.
- wrap: registered. It is high only in the cycle after the wrapping edge and low otherwise, including in direct mode.
- Reset mid-scan: cur_sel returns to 0 and q_valid drops to 0. Scanning resumes from channel 0 once enable is high.
- Mode switch:
  - scan 1->0: cur_sel holds its last value.
  - scan 0->1: the scan starts from the current cur_sel.
- Widths: all select arithmetic is SEL_W bits. For non-power-of-2 CHANNELS the wrap uses an explicit compare against CHANNELS-1, not natural overflow.

Optional Feature:
- Macro: MUXN_SKIP_MASK_EN.
- When defined:
  - Adds input port mask (CHANNELS bits, 1 = channel skipped).
  - Scan steps to the next unmasked channel in circular order. wrap pulses whenever the step passes through index CHANNELS-1 to a lower index.
  - If all channels are masked, cur_sel holds, no capture occurs and q_valid is cleared to 0.
  - Direct-mode loads of a masked channel are ignored.
  - A capture with cur_sel pointing at a masked channel does not update q and clears q_valid.
- When not defined: no mask port; every channel is scanned in sequence.

Test Plan:
- Reset: hold reset 2 cycles with enable=1, scan=1 -> q=0, q_valid=0, cur_sel=0, wrap=0.
  - Repeat mid-scan at cur_sel=2 -> same values on the next edge.
- Direct select (WIDTH=8, CHANNELS=4, d={8'h44,8'h33,8'h22,8'h11}):
  - sel_in=2, sel_load=1 -> cur_sel=2 after 1 edge.
  - enable=1 -> q=8'h33 and q_valid=1 one edge later.
- Scan: scan=1, enable held high, same d -> q sequence 11,22,33,44,11.
  - wrap high exactly once per 4 captures, in the cycle after cur_sel goes 3->0.
- Priority and illegal select:
  - CHANNELS=5, sel_in=6, sel_load=1 -> cur_sel unchanged.
  - scan=1 with sel_load=1, sel_in=0 at cur_sel=3 -> cur_sel=4.
  - Next scan step -> cur_sel=0 with wrap.
- Enable gating: scan=1, enable toggled 1,0,0,1 -> cur_sel advances only on the two high cycles; q holds during the low cycles.
- MUXN_SKIP_MASK_EN: mask=4'b0101, scan -> cur_sel visits 1,3,1,3; q alternates 22,44.
  - mask=4'b1111 -> cur_sel holds and q_valid=0.
